// File: rtl/change_dispenser.sv
// change_dispenser: pays out change in 20p/10p coins, greedy 20p first.
// Each eject request is held until coin_ack or a timeout. A timeout
// parks the block in FAULT, which only reset clears.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   start                 one-cycle payout request (honoured only in IDLE)
//   change_units[2:0]     amount owed in 10p units, sampled with start
//   coin_ack              mechanism acknowledge (level)
//   eject_20, eject_10    coin release requests (level)
//   busy                  payout in progress
//   done                  one-cycle completion pulse
//   fault                 sticky mechanism-timeout flag
//   remaining[2:0]        10p units still unpaid
module change_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] change_units,
    input  logic       coin_ack,
    output logic       eject_20,
    output logic       eject_10,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] remaining
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned UNITS_W = 3;
    // Last cycle an eject may wait: on this count the eject has been
    // requested for ACK_TIMEOUT cycles.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        EJ20   = 3'd2,
        EJ10   = 3'd3,
        GAP    = 3'd4,
        DONE   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [UNITS_W-1:0] remaining_next;
    logic [CNT_W-1:0]   ack_cnt;
    logic [CNT_W-1:0]   ack_cnt_next;

    // State, counter and registered outputs; outputs decode the next state
    // so they line up with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            ack_cnt   <= '0;
            eject_20  <= 1'b0;
            eject_10  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            ack_cnt   <= ack_cnt_next;
            eject_20  <= (state_next == EJ20);
            eject_10  <= (state_next == EJ10);
            busy      <= (state_next == SELECT) || (state_next == EJ20) ||
                         (state_next == EJ10)   || (state_next == GAP);
            done      <= (state_next == DONE);
            fault     <= (state_next == FAULT);
        end
    end

    // Next-state, remaining and timeout-counter logic.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        ack_cnt_next   = ack_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    remaining_next = change_units;
                    state_next     = SELECT;
                end
            end

            SELECT: begin
                ack_cnt_next = '0;
                if (remaining >= UNITS_W'(2)) begin
                    state_next = EJ20;
                end else if (remaining == UNITS_W'(1)) begin
                    state_next = EJ10;
                end else begin
                    state_next = DONE;
                end
            end

            // Ack takes priority over a timeout landing on the same cycle.
            EJ20: begin
                if (coin_ack) begin
                    if (remaining >= UNITS_W'(2)) begin
                        remaining_next = remaining - UNITS_W'(2);
                    end
                    state_next = GAP;
                end else if (ack_cnt == TIMEOUT_LAST) begin
                    state_next = FAULT;
                end else begin
                    ack_cnt_next = ack_cnt + CNT_W'(1);
                end
            end

            EJ10: begin
                if (coin_ack) begin
                    if (remaining != '0) begin
                        remaining_next = remaining - UNITS_W'(1);
                    end
                    state_next = GAP;
                end else if (ack_cnt == TIMEOUT_LAST) begin
                    state_next = FAULT;
                end else begin
                    ack_cnt_next = ack_cnt + CNT_W'(1);
                end
            end

            GAP: begin
                state_next = SELECT;
            end

            DONE: begin
                remaining_next = '0;
                state_next     = IDLE;
            end

            FAULT: begin
                state_next = FAULT;
            end

            default: begin
                state_next     = IDLE;
                remaining_next = '0;
                ack_cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, is the maximum number of clock cycles an eject request waits for coin_ack before a fault is raised (range 1..255).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to pay out change_units.
REQ-005 change_units  input  3  change owed, in 10p units (0..7), sampled only with an accepted start.
REQ-006 coin_ack  input  1  level from the coin mechanism; high means the requested coin has been released.
REQ-007 eject_20  output  1  level request to release one 20p coin.
REQ-008 eject_10  output  1  level request to release one 10p coin.
REQ-009 busy  output  1  high while a payout is in progress.
REQ-010 done  output  1  single-cycle pulse when a payout completes.
REQ-011 fault  output  1  sticky flag for a mechanism timeout.
REQ-012 remaining  output  3  10p units still to be paid.

Function
REQ-013 The FSM states SHALL be IDLE, SELECT, EJ20, EJ10, GAP, DONE and FAULT.
REQ-014 In IDLE, start=1 at edge N SHALL latch change_units into remaining and move to SELECT, with busy=1 after edge N.
REQ-015 start SHALL be ignored in every state other than IDLE, with no change to remaining.
REQ-016 SELECT SHALL move to the next state as follows:
- remaining>=2: go to EJ20.
- remaining==1: go to EJ10.
- remaining==0: go to DONE.
REQ-017 eject_20 SHALL be high exactly while in EJ20, and eject_10 exactly while in EJ10; the two are never high together.
REQ-018 In EJ20 or EJ10, coin_ack=1 at an edge SHALL complete the eject:
- remaining decrements by 2 (EJ20) or 1 (EJ10).
- state moves to GAP.
- the eject line drops after that edge.
REQ-019 coin_ack sampled on the first EJ cycle SHALL count as a valid acknowledge.
REQ-020 GAP SHALL last exactly one cycle with both eject lines low, then move to SELECT, giving a 2-cycle minimum gap between eject requests.
REQ-021 coin_ack in IDLE, SELECT, GAP, DONE or FAULT SHALL be ignored.
REQ-022 Timeout counter:
- An 8-bit counter clears on entry to EJ20/EJ10 and increments each EJ cycle without ack.
- If it reaches ACK_TIMEOUT without ack, the next state is FAULT.
- If ack and timeout coincide in the same cycle, the ack wins.
REQ-023 FAULT outputs and exit:
- eject_20=0, eject_10=0, busy=0, fault=1.
- remaining holds the unpaid units.
- FAULT exits only by reset.
REQ-024 DONE SHALL last one cycle with done=1, busy=0, remaining=0, then return to IDLE.
REQ-025 busy SHALL be high in SELECT, EJ20, EJ10 and GAP only.
REQ-026 Coin selection is greedy (20p first); total cycles from start to done for an ack returned on the first EJ cycle SHALL equal 2 + 3*(number of coins).
REQ-027 remaining SHALL never underflow; the decrement in EJ20 happens only when remaining>=2.

Reset
REQ-028 Asserting reset at any time, including mid-eject, SHALL immediately force:
- state IDLE.
- eject_20=0, eject_10=0, busy=0, done=0, fault=0, remaining=0.
- timeout counter=0.
REQ-029 After reset deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-030 change_units=5, start pulse, coin_ack asserted on the first cycle of each eject -> eject_20 requested twice then eject_10 once; remaining 5->3->1->0; done pulses 11 cycles after the start edge.
REQ-031 change_units=0, start pulse -> no eject; SELECT then DONE; done=1 two cycles after the start edge.
REQ-032 change_units=2, coin_ack held low -> eject_20 high for ACK_TIMEOUT cycles, then fault=1, eject_20=0, remaining=2; a new start is ignored.
REQ-033 Ack on the exact cycle the timeout counter reaches ACK_TIMEOUT -> coin counted, no fault, payout continues.
REQ-034 start pulses while busy=1 with change_units=7 -> ignored; original payout completes unchanged.
REQ-035 Reset asserted while eject_10=1 -> all outputs 0 immediately; next start with change_units=1 pays one 10p coin normally.
